// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//   Command-driven 8-bit shift/rotate sequencer. A start in IDLE captures
//   pattern/dir/mode/steps. The next edge (LOAD) puts the pattern into q. The
//   block then performs one shift step every PRESCALE clocks until `steps`
//   steps are done. It pulses done for one cycle and then returns to IDLE.
//
// Parameters
//   PRESCALE  clk cycles per shift step (1..255)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      command request, sampled only while busy=0
//   pattern    value loaded into q at the start of a command
//   dir        0 = toward MSB (left), 1 = toward LSB (right)
//   mode       0 = rotate, 1 = logical shift with zero fill
//   steps      number of shift steps, 0..15
//   q          shift register contents
//   busy       high in LOAD, RUN and DONE
//   done       one-cycle completion pulse (DONE state)
//   step_cnt   steps completed in the current or last command
//   state_dbg  current FSM state, for observation only
//
// Handshake: start is a request with no acknowledge. It is taken on any rising
// edge where busy=0 and start=1, and it is ignored on every edge where busy=1.
// -----------------------------------------------------------------------------
module shift_seq_ctrl #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] pattern,
  input  logic       dir,
  input  logic       mode,
  input  logic [3:0] steps,
  output logic [7:0] q,
  output logic       busy,
  output logic       done,
  output logic [3:0] step_cnt,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Terminal prescaler count. With PRESCALE=1 this is 0, so every RUN cycle steps.
  localparam logic [7:0] PRESC_TC = 8'(PRESCALE - 1);

  logic [1:0] state;
  logic [7:0] presc;
  logic [7:0] pattern_r;
  logic       dir_r;
  logic       mode_r;
  logic [3:0] steps_r;
  logic [3:0] cnt_inc;

  // One shift/rotate step. In shift mode the vacated bit is filled with zero.
  function automatic logic [7:0] step_fn(input logic [7:0] v, input logic d,
                                         input logic m);
    logic [7:0] r;
    if (!d) r = {v[6:0], (m ? 1'b0 : v[7])};
    else    r = {(m ? 1'b0 : v[0]), v[7:1]};
    return r;
  endfunction

  assign cnt_inc = step_cnt + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      q         <= 8'h55;
      step_cnt  <= 4'd0;
      presc     <= 8'd0;
      pattern_r <= 8'd0;
      dir_r     <= 1'b0;
      mode_r    <= 1'b0;
      steps_r   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pattern_r <= pattern;
            dir_r     <= dir;
            mode_r    <= mode;
            steps_r   <= steps;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          q        <= pattern_r;
          step_cnt <= 4'd0;
          presc    <= 8'd0;
          state    <= (steps_r == 4'd0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (presc == PRESC_TC) begin
            presc    <= 8'd0;
            q        <= step_fn(q, dir_r, mode_r);
            step_cnt <= cnt_inc;
            if (cnt_inc == steps_r) state <= ST_DONE;
          end else begin
            presc <= presc + 8'd1;
          end
        end
        default: begin
          // DONE: always a single cycle; q and step_cnt hold until the next LOAD.
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // These are decoded from the state register, so reset clears them at once.
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1;
  logic [7:0] pattern;
  logic       dir, mode;
  logic [3:0] steps;
  logic [7:0] q, q1;
  logic       busy, done, busy1, done1;
  logic [3:0] step_cnt, step_cnt1;
  logic [1:0] state_dbg, state_dbg1;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .dir(dir),
    .mode(mode), .steps(steps), .q(q), .busy(busy), .done(done),
    .step_cnt(step_cnt), .state_dbg(state_dbg)
  );

  shift_seq_ctrl #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pattern(pattern), .dir(dir),
    .mode(mode), .steps(steps), .q(q1), .busy(busy1), .done(done1),
    .step_cnt(step_cnt1), .state_dbg(state_dbg1)
  );

  // Watchdog: the run must always end by itself.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Advance to the negedge after the next n rising edges.
  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue a command to the PRESCALE=4 instance. The task returns at the negedge
  // after the accepting edge E0, with the inputs already scrambled.
  task automatic do_start(input logic [7:0] p, input logic d, input logic m,
                          input logic [3:0] s);
    @(negedge clk);
    pattern = p; dir = d; mode = m; steps = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pattern = 8'($urandom_range(0, 255));
    dir = 1'($urandom_range(0, 1));
    mode = 1'($urandom_range(0, 1));
    steps = 4'($urandom_range(0, 15));
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    pattern = 8'h00; dir = 1'b0; mode = 1'b0; steps = 4'd0;
    wait_edges(2);
    nvec++; if (q !== 8'h55) begin nfail++; $display("FAIL reset_q: got %h expected 55", q); end
    nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    nvec++; if (done !== 1'b0) begin nfail++; $display("FAIL reset_done: got %b expected 0", done); end
    nvec++; if (step_cnt !== 4'd0) begin nfail++; $display("FAIL reset_cnt: got %0d expected 0", step_cnt); end
    nvec++; if (state_dbg !== 2'd0) begin nfail++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    rst = 1'b0;
    wait_edges(1);
    nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  // 0x81, rotate left, 1 step.
  task automatic test_single_step;
    do_start(8'h81, 1'b0, 1'b0, 4'd1);
    nvec++; if (busy !== 1'b1) begin nfail++; $display("FAIL e0_busy: got %b expected 1", busy); end
    nvec++; if (q !== 8'h55) begin nfail++; $display("FAIL e0_q_hold: got %h expected 55", q); end
    wait_edges(1);
    nvec++; if (q !== 8'h81) begin nfail++; $display("FAIL e1_q: got %h expected 81", q); end
    nvec++; if (step_cnt !== 4'd0) begin nfail++; $display("FAIL e1_cnt: got %0d expected 0", step_cnt); end
    wait_edges(3);
    nvec++; if (q !== 8'h81) begin nfail++; $display("FAIL e4_q_no_step: got %h expected 81", q); end
    wait_edges(1);
    nvec++; if (q !== 8'h03) begin nfail++; $display("FAIL e5_q: got %h expected 03", q); end
    nvec++; if (done !== 1'b1) begin nfail++; $display("FAIL e5_done: got %b expected 1", done); end
    nvec++; if (step_cnt !== 4'd1) begin nfail++; $display("FAIL e5_cnt: got %0d expected 1", step_cnt); end
    wait_edges(1);
    nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL e6_busy: got %b expected 0", busy); end
    nvec++; if (done !== 1'b0) begin nfail++; $display("FAIL e6_done: got %b expected 0", done); end
    nvec++; if (q !== 8'h03) begin nfail++; $display("FAIL e6_q_hold: got %h expected 03", q); end
  endtask

  // 0x01, rotate right, 3 steps: 01 -> 80 -> 40 -> 20.
  task automatic test_rotate_right;
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h80; exp_q[1] = 8'h40; exp_q[2] = 8'h20;
    do_start(8'h01, 1'b1, 1'b0, 4'd3);
    wait_edges(1);
    nvec++; if (q !== 8'h01) begin nfail++; $display("FAIL rr_load: got %h expected 01", q); end
    for (int k = 0; k < 3; k++) begin
      wait_edges(4);
      nvec++; if (q !== exp_q[k]) begin nfail++; $display("FAIL rr_step%0d: got %h expected %h", k + 1, q, exp_q[k]); end
    end
    nvec++; if (done !== 1'b1) begin nfail++; $display("FAIL rr_done: got %b expected 1", done); end
    nvec++; if (step_cnt !== 4'd3) begin nfail++; $display("FAIL rr_cnt: got %0d expected 3", step_cnt); end
    wait_edges(1);
  endtask

  // 0xFF, 8 steps left: the shift ends at 0x00 and the rotate returns to 0xFF.
  // done is reached 1+8*4 = 33 edges after E0.
  task automatic test_full_width;
    do_start(8'hFF, 1'b0, 1'b1, 4'd8);
    wait_edges(32);
    nvec++; if (done !== 1'b0) begin nfail++; $display("FAIL shl_early_done: got %b expected 0", done); end
    wait_edges(1);
    nvec++; if (done !== 1'b1) begin nfail++; $display("FAIL shl_done: got %b expected 1", done); end
    nvec++; if (q !== 8'h00) begin nfail++; $display("FAIL shl_q: got %h expected 00", q); end
    nvec++; if (step_cnt !== 4'd8) begin nfail++; $display("FAIL shl_cnt: got %0d expected 8", step_cnt); end
    wait_edges(1);
    do_start(8'hFF, 1'b0, 1'b0, 4'd8);
    wait_edges(33);
    nvec++; if (done !== 1'b1) begin nfail++; $display("FAIL rol_done: got %b expected 1", done); end
    nvec++; if (q !== 8'hFF) begin nfail++; $display("FAIL rol_q: got %h expected ff", q); end
    wait_edges(1);
  endtask

  // steps=0: load, then DONE straight away.
  task automatic test_zero_steps;
    do_start(8'hA5, 1'b1, 1'b1, 4'd0);
    wait_edges(1);
    nvec++; if (q !== 8'hA5) begin nfail++; $display("FAIL z_q: got %h expected a5", q); end
    nvec++; if (done !== 1'b1) begin nfail++; $display("FAIL z_done: got %b expected 1", done); end
    nvec++; if (step_cnt !== 4'd0) begin nfail++; $display("FAIL z_cnt: got %0d expected 0", step_cnt); end
    wait_edges(1);
    nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL z_busy: got %b expected 0", busy); end
  endtask

  // start held high with pattern 0x00 through RUN and DONE is ignored. It is
  // then accepted in the first IDLE cycle.
  task automatic test_back_to_back;
    do_start(8'h3C, 1'b0, 1'b0, 4'd2);
    pattern = 8'h00; dir = 1'b0; mode = 1'b0; steps = 4'd2; start = 1'b1;
    wait_edges(5);
    nvec++; if (q !== 8'h78) begin nfail++; $display("FAIL b2b_step1: got %h expected 78", q); end
    nvec++; if (step_cnt !== 4'd1) begin nfail++; $display("FAIL b2b_cnt1: got %0d expected 1", step_cnt); end
    wait_edges(4);
    nvec++; if (q !== 8'hF0) begin nfail++; $display("FAIL b2b_step2: got %h expected f0", q); end
    nvec++; if (done !== 1'b1) begin nfail++; $display("FAIL b2b_done: got %b expected 1", done); end
    wait_edges(1);
    nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL b2b_idle: got %b expected 0", busy); end
    nvec++; if (q !== 8'hF0) begin nfail++; $display("FAIL b2b_q_hold: got %h expected f0", q); end
    wait_edges(1);
    nvec++; if (busy !== 1'b1) begin nfail++; $display("FAIL b2b_accept: got %b expected 1", busy); end
    start = 1'b0;
    wait_edges(1);
    nvec++; if (q !== 8'h00) begin nfail++; $display("FAIL b2b_reload: got %h expected 00", q); end
    wait_edges(8);
    nvec++; if (done !== 1'b1) begin nfail++; $display("FAIL b2b_done2: got %b expected 1", done); end
    wait_edges(1);
  endtask

  // Reset asserted mid-RUN takes effect with no clock edge, and a later command
  // runs normally.
  task automatic test_reset_mid_run;
    do_start(8'hF1, 1'b1, 1'b1, 4'd5);
    wait_edges(5);
    nvec++; if (q !== 8'h78) begin nfail++; $display("FAIL shr_step1: got %h expected 78", q); end
    #2 rst = 1'b1;
    #1;
    nvec++; if (q !== 8'h55) begin nfail++; $display("FAIL mid_rst_q: got %h expected 55", q); end
    nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    nvec++; if (done !== 1'b0) begin nfail++; $display("FAIL mid_rst_done: got %b expected 0", done); end
    nvec++; if (step_cnt !== 4'd0) begin nfail++; $display("FAIL mid_rst_cnt: got %0d expected 0", step_cnt); end
    wait_edges(2);
    rst = 1'b0;
    wait_edges(1);
    nvec++; if (busy !== 1'b0 || done !== 1'b0) begin nfail++; $display("FAIL post_rst_idle: got busy=%b done=%b expected 0/0", busy, done); end
    do_start(8'h81, 1'b0, 1'b0, 4'd1);
    wait_edges(5);
    nvec++; if (q !== 8'h03) begin nfail++; $display("FAIL post_rst_q: got %h expected 03", q); end
    nvec++; if (done !== 1'b1) begin nfail++; $display("FAIL post_rst_done: got %b expected 1", done); end
    wait_edges(1);
  endtask

  // PRESCALE=1: one step per cycle, shift right 0x81 -> 40 -> 20 -> 10.
  task automatic test_prescale_one;
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h40; exp_q[1] = 8'h20; exp_q[2] = 8'h10;
    @(negedge clk);
    pattern = 8'h81; dir = 1'b1; mode = 1'b1; steps = 4'd3; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    wait_edges(2);
    nvec++; if (q1 !== 8'h81) begin nfail++; $display("FAIL p1_load: got %h expected 81", q1); end
    for (int k = 0; k < 3; k++) begin
      wait_edges(1);
      nvec++; if (q1 !== exp_q[k]) begin nfail++; $display("FAIL p1_step%0d: got %h expected %h", k + 1, q1, exp_q[k]); end
    end
    nvec++; if (done1 !== 1'b1) begin nfail++; $display("FAIL p1_done: got %b expected 1", done1); end
    nvec++; if (step_cnt1 !== 4'd3) begin nfail++; $display("FAIL p1_cnt: got %0d expected 3", step_cnt1); end
    wait_edges(1);
    nvec++; if (busy1 !== 1'b0) begin nfail++; $display("FAIL p1_busy: got %b expected 0", busy1); end
  endtask

  initial begin
    test_reset;
    test_single_step;
    test_rotate_right;
    test_full_width;
    test_zero_steps;
    test_back_to_back;
    test_reset_mid_run;
    test_prescale_one;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 4, meaning clk cycles per shift step (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: command request, sampled only while busy=0.
REQ-005 The block SHALL have port pattern, input, 8 bits: value loaded into q at the start of a command.
REQ-006 The block SHALL have port dir, input, 1 bit: 0 = left (toward MSB), 1 = right (toward LSB).
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = rotate, 1 = logical shift with zero fill.
REQ-008 The block SHALL have port steps, input, 4 bits: number of shift steps, 0..15.
REQ-009 The block SHALL have port q, output, 8 bits: shift register contents.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a command is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port step_cnt, output, 4 bits: number of steps completed in the current or last command.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, RUN and DONE; busy=1 in LOAD, RUN and DONE, and done=1 only in DONE.
REQ-014 In IDLE with start=1 at an edge (E0), the block SHALL latch pattern, dir, mode and steps into internal registers and go to LOAD; the inputs are don't-care afterwards.
REQ-015 At edge E1 in LOAD, the block SHALL set q to the latched pattern, clear step_cnt and the prescaler, then go to DONE if steps=0, else to RUN.
REQ-016 In RUN, the prescaler SHALL count 0..PRESCALE-1 and perform exactly one step on terminal count, so step k occurs at edge E1+k*PRESCALE.
REQ-017 The step SHALL be: rotate-left q[0]<=q[7], q[i]<=q[i-1]; rotate-right q[7]<=q[0], q[i]<=q[i+1]; shift modes identical except the vacated bit is 0.
REQ-018 step_cnt SHALL increment with each step; on the step where step_cnt reaches steps, the FSM SHALL go to DONE.
REQ-019 DONE SHALL last exactly one cycle and then return to IDLE; q and step_cnt SHALL hold until the next LOAD.
REQ-020 start SHALL be ignored while busy=1, including in DONE; a start in the first IDLE cycle after DONE SHALL be accepted.
REQ-021 q SHALL change only in LOAD, on a RUN step edge, or on reset.
REQ-022 With PRESCALE=1, the block SHALL perform a step every cycle in RUN with no idle cycles.

Reset
REQ-023 While rst=1, asynchronously: q=8'h55, state=IDLE, busy=0, done=0, step_cnt=0, prescaler=0, latched command registers=0.
REQ-024 Reset asserted mid-command SHALL abort it immediately with no done pulse; operation resumes at the first edge after rst falls.

Verification
REQ-025 Assert rst mid-RUN -> q=0x55, busy=0, done=0 without waiting for a clock edge; a start issued after release runs normally.
REQ-026 pattern=0x81, dir=0, mode=0, steps=1, PRESCALE=4 -> q=0x81 after E1, q=0x03 after E5, done high during the cycle after E5, busy low after E6.
REQ-027 pattern=0x01, dir=1, mode=0, steps=3 -> q sequence 0x01, 0x80, 0x40, 0x20; step_cnt=3 at done.
REQ-028 pattern=0xFF, dir=0, mode=1, steps=8 -> q ends at 0x00; done occurs 1+8*PRESCALE edges after E0; rotate mode with the same setup -> q returns to 0xFF.
REQ-029 pattern=0xA5, steps=0 -> q=0xA5 after E1, done pulse in the cycle after E1, step_cnt=0.
REQ-030 start pulses with pattern=0x00 during RUN and DONE -> ignored; q and step_cnt follow the original command only.
